// File: rtl/memreq_port_if.sv
// Lane bundle between a client, memreq_port and one memory block request lane.
// slave is the memreq_port view; master is the environment view (client plus memory block).
interface memreq_port_if #(
    parameter int unsigned TAGW = 6
);
    // Client command channel
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [38:0]     req_addr;
    logic [39:0]     req_phy;
    logic [532:0]    req_wdata;
    logic [TAGW-1:0] req_tag;

    // Memory block request side
    logic [38:0]     mb_rdaddr0;
    logic [39:0]     mb_rdphydata0;
    logic            mb_rden_in;
    logic [38:0]     mb_wraddr0;
    logic [532:0]    mb_wrdata;
    logic            mb_wren_in;
    logic            mb_stall;

    // Memory block read return
    logic            mb_rden_out;
    logic [532:0]    mb_rddata;
    logic [39:0]     mb_rdphydata;

    // Client response channel
    logic            rsp_valid;
    logic            rsp_ready;
    logic [TAGW-1:0] rsp_tag;
    logic [532:0]    rsp_data;
    logic [39:0]     rsp_phy;
    logic            err;

    modport slave (
        input  req_valid, req_we, req_addr, req_phy, req_wdata, req_tag,
        output req_ready,
        output mb_rdaddr0, mb_rdphydata0, mb_rden_in,
        output mb_wraddr0, mb_wrdata, mb_wren_in,
        input  mb_stall,
        input  mb_rden_out, mb_rddata, mb_rdphydata,
        output rsp_valid, rsp_tag, rsp_data, rsp_phy, err,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_we, req_addr, req_phy, req_wdata, req_tag,
        input  req_ready,
        input  mb_rdaddr0, mb_rdphydata0, mb_rden_in,
        input  mb_wraddr0, mb_wrdata, mb_wren_in,
        output mb_stall,
        output mb_rden_out, mb_rddata, mb_rdphydata,
        input  rsp_valid, rsp_tag, rsp_data, rsp_phy, err,
        output rsp_ready
    );
endinterface

// File: rtl/memreq_port.sv
// Single-lane memory initiator: one-entry output stage toward the memory block,
// in-order read tag tracking, and a credit-protected first-word-fall-through response FIFO.
// The memory block itself is never reset, so a post-reset blanking window of LAT unstalled
// edges discards whatever was still in its read pipeline.
module memreq_port #(
    parameter int unsigned LAT       = 48,
    parameter int unsigned RSP_DEPTH = 16,
    parameter int unsigned TAGW      = 6
) (
    input logic          clk,
    input logic          rst,
    memreq_port_if.slave bus
);

    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
    localparam int unsigned AW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned BW = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam int unsigned RW = TAGW + 533 + 40;

    // Pointer advance that also works for non power-of-two depths
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(RSP_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // ---------------------------------------------------------------------
    // Blanking
    // ---------------------------------------------------------------------
    logic [BW-1:0] blank_q;
    logic          blank;

    assign blank = (blank_q != '0);

    // Count down LAT unstalled edges after reset before trusting the return path
    always_ff @(posedge clk) begin
        if (rst) begin
            blank_q <= BW'(LAT);
        end else if (blank && !bus.mb_stall) begin
            blank_q <= blank_q - BW'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Handshake decode
    // ---------------------------------------------------------------------
    logic          ov_q;
    logic [CW-1:0] credit_q;
    logic          accept;
    logic          rd_accept;
    logic          rsp_pop;
    logic          capture;
    logic          tag_pop;
    logic          orphan;
    logic [CW-1:0] tag_cnt_q;
    logic [CW-1:0] rsp_cnt_q;

    assign bus.req_ready = ~blank & (~ov_q | ~bus.mb_stall) & (credit_q != '0);
    assign accept        = bus.req_valid & bus.req_ready;
    assign rd_accept     = accept & ~bus.req_we;

    assign bus.rsp_valid = (rsp_cnt_q != '0);
    assign rsp_pop       = bus.rsp_valid & bus.rsp_ready;

    assign capture = bus.mb_rden_out & ~bus.mb_stall & ~blank;
    assign tag_pop = capture & (tag_cnt_q != '0);
    assign orphan  = capture & (tag_cnt_q == '0);

    // ---------------------------------------------------------------------
    // Output stage
    // ---------------------------------------------------------------------
    logic         we_q;
    logic [38:0]  addr_q;
    logic [39:0]  phy_q;
    logic [532:0] wdata_q;

    // Valid bit: refill wins over retire; the block only consumes on unstalled edges
    always_ff @(posedge clk) begin
        if (rst) begin
            ov_q <= 1'b0;
        end else if (accept) begin
            ov_q <= 1'b1;
        end else if (!bus.mb_stall) begin
            ov_q <= 1'b0;
        end
    end

    // Payload only changes on accept, so it stays stable for as long as ov is held
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            phy_q   <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            phy_q   <= bus.req_phy;
            wdata_q <= bus.req_wdata;
        end
    end

    assign bus.mb_rden_in    = ov_q & ~we_q;
    assign bus.mb_wren_in    = ov_q & we_q;
    assign bus.mb_rdaddr0    = addr_q;
    assign bus.mb_rdphydata0 = phy_q;
    assign bus.mb_wraddr0    = addr_q;
    assign bus.mb_wrdata     = wdata_q;

    // ---------------------------------------------------------------------
    // Read credits: one per response FIFO slot, returned when the client pops
    // ---------------------------------------------------------------------

    // Reads take a credit, pops give one back; both together cancel out
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q <= CW'(RSP_DEPTH);
        end else begin
            case ({rd_accept, rsp_pop})
                2'b10:   credit_q <= credit_q - CW'(1);
                2'b01:   credit_q <= credit_q + CW'(1);
                default: credit_q <= credit_q;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Tag FIFO: tags of reads issued but not yet returned, in issue order
    // ---------------------------------------------------------------------
    logic [TAGW-1:0] tag_mem [RSP_DEPTH];
    logic [AW-1:0]   tag_wr_q;
    logic [AW-1:0]   tag_rd_q;

    // Tag storage needs no reset; the pointers and count define what is live
    always_ff @(posedge clk) begin
        if (rd_accept) begin
            tag_mem[tag_wr_q] <= bus.req_tag;
        end
    end

    // Tag FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_wr_q  <= '0;
            tag_rd_q  <= '0;
            tag_cnt_q <= '0;
        end else begin
            if (rd_accept) begin
                tag_wr_q <= ptr_inc(tag_wr_q);
            end
            if (tag_pop) begin
                tag_rd_q <= ptr_inc(tag_rd_q);
            end
            case ({rd_accept, tag_pop})
                2'b10:   tag_cnt_q <= tag_cnt_q + CW'(1);
                2'b01:   tag_cnt_q <= tag_cnt_q - CW'(1);
                default: tag_cnt_q <= tag_cnt_q;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Response FIFO (first-word fall-through)
    // ---------------------------------------------------------------------
    logic [RW-1:0] rsp_mem [RSP_DEPTH];
    logic [AW-1:0] rsp_wr_q;
    logic [AW-1:0] rsp_rd_q;
    logic [RW-1:0] rsp_head;

    // Capture a return together with the tag of the oldest outstanding read
    always_ff @(posedge clk) begin
        if (tag_pop) begin
            rsp_mem[rsp_wr_q] <= {tag_mem[tag_rd_q], bus.mb_rddata, bus.mb_rdphydata};
        end
    end

    // Response FIFO pointers and occupancy; credits guarantee no push when full
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_wr_q  <= '0;
            rsp_rd_q  <= '0;
            rsp_cnt_q <= '0;
        end else begin
            if (tag_pop) begin
                rsp_wr_q <= ptr_inc(rsp_wr_q);
            end
            if (rsp_pop) begin
                rsp_rd_q <= ptr_inc(rsp_rd_q);
            end
            case ({tag_pop, rsp_pop})
                2'b10:   rsp_cnt_q <= rsp_cnt_q + CW'(1);
                2'b01:   rsp_cnt_q <= rsp_cnt_q - CW'(1);
                default: rsp_cnt_q <= rsp_cnt_q;
            endcase
        end
    end

    // Payload is forced to zero when empty so outputs are defined out of reset
    always_comb begin
        rsp_head = '0;
        if (bus.rsp_valid) begin
            rsp_head = rsp_mem[rsp_rd_q];
        end
    end

    assign bus.rsp_tag  = rsp_head[RW-1 -: TAGW];
    assign bus.rsp_data = rsp_head[572:40];
    assign bus.rsp_phy  = rsp_head[39:0];

    // ---------------------------------------------------------------------
    // Error flag
    // ---------------------------------------------------------------------

    // Sticky until reset: a return arrived with no read outstanding
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.err <= 1'b0;
        end else if (orphan) begin
            bus.err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_memreq_port.sv
// Directed bench for memreq_port with a LAT-deep, stall-aware memory block read model.
module tb_memreq_port;

    localparam int unsigned LAT       = 48;
    localparam int unsigned RSP_DEPTH = 16;
    localparam int unsigned TAGW      = 6;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    memreq_port_if #(.TAGW(TAGW)) bus ();

    memreq_port #(
        .LAT       (LAT),
        .RSP_DEPTH (RSP_DEPTH),
        .TAGW      (TAGW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line returned by the memory model for a given address
    function automatic logic [532:0] line_of(input logic [38:0] a);
        logic [535:0] pat;
        pat = {67{8'hA5}};
        return pat[532:0] ^ {494'd0, a};
    endfunction

    function automatic logic [39:0] phy_of(input logic [38:0] a);
        return {1'b1, a};
    endfunction

    // Memory block read pipeline model: never reset by rst, advances only when unstalled
    logic        mdl_clr;
    logic        inj_rden;
    logic        pv [LAT];
    logic [38:0] pa [LAT];
    logic [39:0] pp [LAT];

    always @(posedge clk) begin
        if (mdl_clr) begin
            for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
        end else if (!bus.mb_stall) begin
            pv[0] <= bus.mb_rden_in;
            pa[0] <= bus.mb_rdaddr0;
            pp[0] <= bus.mb_rdphydata0;
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
                pp[i] <= pp[i-1];
            end
        end
    end

    assign bus.mb_rden_out  = pv[LAT-1] | inj_rden;
    assign bus.mb_rddata    = line_of(inj_rden ? 39'd0 : pa[LAT-1]);
    assign bus.mb_rdphydata = inj_rden ? 40'd0 : pp[LAT-1];

    // Entered and left on a negedge; waits for the head, checks it, then pops it
    task automatic drain_one(input int t, input logic [38:0] a);
        int w;
        logic [532:0] exp_line;
        w = 0;
        exp_line = line_of(a);
        while (!bus.rsp_valid && w < 200) begin
            @(posedge clk);
            @(negedge clk);
            w++;
        end
        check_eq("rsp_wait", 64'(bus.rsp_valid), 64'd1);
        check_eq("rsp_tag", 64'(bus.rsp_tag), 64'(t));
        check_eq("rsp_data_lo", bus.rsp_data[63:0], exp_line[63:0]);
        check_eq("rsp_data_hi", bus.rsp_data[532:469], exp_line[532:469]);
        check_eq("rsp_phy", 64'(bus.rsp_phy), 64'(phy_of(a)));
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    // Offer reads with consecutive tags/addresses for max cycles; n = number accepted
    task automatic burst(input int base_tag, input logic [38:0] base_addr, input int max,
                         output int n);
        logic rdy;
        n = 0;
        for (int k = 0; k < max; k++) begin
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b0;
            bus.req_tag   = TAGW'(base_tag + n);
            bus.req_addr  = base_addr + 39'(n);
            bus.req_phy   = phy_of(base_addr + 39'(n));
            rdy = bus.req_ready;
            @(posedge clk);
            #1;
            if (rdy) n++;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int k;
        logic [38:0]  a;
        logic [532:0] wd;

        rst           = 1'b1;
        mdl_clr       = 1'b1;
        inj_rden      = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_phy   = '0;
        bus.req_wdata = '0;
        bus.req_tag   = '0;
        bus.mb_stall  = 1'b0;
        bus.rsp_ready = 1'b0;

        // Reset and blanking
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check_eq("rst_rden_in", 64'(bus.mb_rden_in), 64'd0);
        check_eq("rst_wren_in", 64'(bus.mb_wren_in), 64'd0);
        check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("rst_err", 64'(bus.err), 64'd0);
        check_eq("rst_rsp_data", bus.rsp_data[63:0], 64'd0);
        rst     = 1'b0;
        mdl_clr = 1'b0;
        n = 0;
        while (!bus.req_ready && n < 200) begin
            inj_rden = (n >= 5 && n < 10);
            n++;
            @(negedge clk);
        end
        inj_rden = 1'b0;
        check_eq("blank_len", 64'(n), 64'd48);
        check_eq("blank_no_rsp", 64'(bus.rsp_valid), 64'd0);
        check_eq("blank_no_err", 64'(bus.err), 64'd0);

        // Single read
        a = 39'h12_3456_7890;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = a;
        bus.req_phy   = phy_of(a);
        bus.req_tag   = 6'd5;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check_eq("rd_rden_in", 64'(bus.mb_rden_in), 64'd1);
        check_eq("rd_wren_in", 64'(bus.mb_wren_in), 64'd0);
        check_eq("rd_addr", 64'(bus.mb_rdaddr0), 64'(a));
        check_eq("rd_phy", 64'(bus.mb_rdphydata0), 64'(phy_of(a)));
        k = 0;
        while (!bus.rsp_valid && k < 200) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            if (k == 1) check_eq("rd_one_cycle", 64'(bus.mb_rden_in), 64'd0);
        end
        check_eq("rd_latency", 64'(k), 64'd49);
        drain_one(5, a);
        check_eq("rd_empty", 64'(bus.rsp_valid), 64'd0);

        // Stall hold on a write
        a  = 39'h7f_0000_1234;
        wd = ~line_of(a);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_wdata = '0;
        bus.mb_stall  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("st_wren", 64'(bus.mb_wren_in), 64'd1);
            check_eq("st_waddr", 64'(bus.mb_wraddr0), 64'(a));
            check_eq("st_wdata", bus.mb_wrdata[63:0], wd[63:0]);
            check_eq("st_wdata_hi", bus.mb_wrdata[532:469], wd[532:469]);
            check_eq("st_ready", 64'(bus.req_ready), 64'd0);
        end
        check_eq("st_rden", 64'(bus.mb_rden_in), 64'd0);
        bus.mb_stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("st_retired", 64'(bus.mb_wren_in), 64'd0);
        check_eq("st_ready_back", 64'(bus.req_ready), 64'd1);

        // Credit exhaustion
        burst(0, 39'h100, 20, n);
        check_eq("cr_accepts", 64'(n), 64'd16);
        check_eq("cr_ready_low", 64'(bus.req_ready), 64'd0);
        bus.req_valid = 1'b1;
        bus.req_tag   = 6'd16;
        bus.req_addr  = 39'h110;
        bus.req_phy   = phy_of(39'h110);
        repeat (70) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_eq("cr_still_blocked", 64'(bus.req_ready), 64'd0);
        check_eq("cr_head_valid", 64'(bus.rsp_valid), 64'd1);
        check_eq("cr_head_tag", 64'(bus.rsp_tag), 64'd0);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        check_eq("cr_ready_after_pop", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        for (int i = 1; i < 16; i++) drain_one(i, 39'h100 + 39'(i));
        drain_one(16, 39'h110);
        check_eq("cr_empty", 64'(bus.rsp_valid), 64'd0);

        // Simultaneous accept/pop and capture/pop
        bus.req_valid = 1'b1;
        bus.req_tag   = 6'd20;
        bus.req_addr  = 39'h200;
        bus.req_phy   = phy_of(39'h200);
        @(posedge clk);
        #1;
        bus.req_tag   = 6'd21;
        bus.req_addr  = 39'h201;
        bus.req_phy   = phy_of(39'h201);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (47) @(posedge clk);
        @(negedge clk);
        check_eq("sim_not_yet", 64'(bus.rsp_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq("sim_first_valid", 64'(bus.rsp_valid), 64'd1);
        check_eq("sim_first_tag", 64'(bus.rsp_tag), 64'd20);
        check_eq("sim_ready", 64'(bus.req_ready), 64'd1);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_tag   = 6'd22;
        bus.req_addr  = 39'h202;
        bus.req_phy   = phy_of(39'h202);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check_eq("sim_second_valid", 64'(bus.rsp_valid), 64'd1);
        check_eq("sim_second_tag", 64'(bus.rsp_tag), 64'd21);
        check_eq("sim_second_phy", 64'(bus.rsp_phy), 64'(phy_of(39'h201)));
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        check_eq("sim_drained", 64'(bus.rsp_valid), 64'd0);
        // Tag 22 still holds one credit, so 15 remain
        burst(30, 39'h300, 20, n);
        check_eq("sim_credits", 64'(n), 64'd15);
        drain_one(22, 39'h202);
        for (int i = 0; i < 15; i++) drain_one(30 + i, 39'h300 + 39'(i));
        check_eq("sim_empty", 64'(bus.rsp_valid), 64'd0);

        // Orphan return
        repeat (5) @(negedge clk);
        inj_rden = 1'b1;
        @(posedge clk);
        #1;
        inj_rden = 1'b0;
        @(negedge clk);
        check_eq("orph_err", 64'(bus.err), 64'd1);
        check_eq("orph_no_rsp", 64'(bus.rsp_valid), 64'd0);
        repeat (5) @(negedge clk);
        check_eq("orph_err_sticky", 64'(bus.err), 64'd1);
        check_eq("orph_no_rsp_late", 64'(bus.rsp_valid), 64'd0);

        // Reset with a read in flight; its return must be blanked
        bus.req_valid = 1'b1;
        bus.req_tag   = 6'd7;
        bus.req_addr  = 39'h400;
        bus.req_phy   = phy_of(39'h400);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_err_clr", 64'(bus.err), 64'd0);
        check_eq("mid_ready", 64'(bus.req_ready), 64'd0);
        check_eq("mid_rden", 64'(bus.mb_rden_in), 64'd0);
        n = 0;
        while (!bus.req_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        check_eq("mid_blank_len", 64'(n), 64'd48);
        repeat (5) @(negedge clk);
        check_eq("mid_stale_dropped", 64'(bus.rsp_valid), 64'd0);
        check_eq("mid_no_err", 64'(bus.err), 64'd0);

        // Normal read after reset
        bus.req_valid = 1'b1;
        bus.req_tag   = 6'd9;
        bus.req_addr  = 39'h500;
        bus.req_phy   = phy_of(39'h500);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        drain_one(9, 39'h500);
        check_eq("post_empty", 64'(bus.rsp_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
